memory_bus_arbiter: RTL and testbench
=====================================

# memory_bus_arbiter

Two-master, one-slave arbiter for the processor-ci synchronous memory bus (request/response handshake with a registered response pulse). It sits between two requesters and the Controller's single memory port. Typical requesters are a core's instruction and data ports, or a core and a debug/loader master. It serialises transactions with round-robin fairness and guarantees forward progress with a response timeout.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 255, cycles to wait for a slave response before forcing an error response; 0 disables the timeout

Ports (mX = m0 and m1, identical sets):
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- mX_read_request  in  1  level; held until response
- mX_write_request  in  1  level; held until response
- mX_address  in  ADDR_WIDTH  transaction address
- mX_write_data  in  DATA_WIDTH  write data
- mX_write_strobe  in  DATA_WIDTH/8  byte enables
- mX_read_data  out  DATA_WIDTH  valid only while mX_read_response=1
- mX_read_response  out  1  one-cycle pulse
- mX_write_response  out  1  one-cycle pulse
- mX_error  out  1  one-cycle pulse, coincident with a timeout response
- s_read_request, s_write_request  out  1  one-cycle issue pulse
- s_address  out  ADDR_WIDTH  latched address
- s_write_data  out  DATA_WIDTH  latched write data
- s_write_strobe  out  DATA_WIDTH/8  latched strobe; all zeros for reads
- s_read_data  in  DATA_WIDTH  slave read data
- s_read_response, s_write_response  in  1  slave response pulses
- busy  out  1  high in ISSUE/WAIT
- owner  out  1  index of the current or last granted master
- timeout_flag  out  1  sticky; set on any timeout, cleared only by reset

## Operation
- FSM states: IDLE, ISSUE, WAIT. All outputs are registered.
- IDLE:
  - A master is pending if its read or write request is high.
  - If only one master is pending, grant it.
  - If both are pending, grant the master that is not last_grant (round-robin).
  - On grant: latch address, data and strobe; latch the transaction type; update last_grant and owner; go to ISSUE.
- Type: write beats read when a master raises both. The read remains pending and is served by a later transaction.
- ISSUE:
  - Exactly one s_*_request is high for exactly this cycle.
  - s_address, s_write_data and s_write_strobe are stable from ISSUE until the response is taken.
  - The matching slave response is accepted in this cycle (combinational slave) or in WAIT; otherwise go to WAIT.
- WAIT:
  - Hold until the matching response arrives: s_read_response for reads, s_write_response for writes.
  - A non-matching response is ignored.
- On the matching response:
  - Next cycle: pulse the owner's mX_*_response.
  - For reads, mX_read_data = captured s_read_data.
  - Return to IDLE.
  - The non-owner master's outputs stay 0.
- Timeout:
  - A wait counter (width clog2(TIMEOUT_CYCLES+1)) resets on ISSUE and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES: pulse the owner's response and mX_error; mX_read_data = 32'hDEADBEEF (reads); set timeout_flag; return to IDLE.
  - A slave response arriving after the timeout is ignored.
- A master holding its request after receiving a response is treated as a new transaction. The next IDLE evaluation applies round-robin.
- Reset values:
  - All outputs 0; state IDLE.
  - last_grant=1, so m0 wins the first contention.
  - Counter 0; timeout_flag 0.
- Reset mid-transaction: abort. No response pulse is issued, and all outputs are 0 after the reset edge.

## Timing
- Request seen high in IDLE at cycle N:
  - s_*_request at N+1.
  - Slave response at N+1 gives the master response at N+2 (minimum latency 2).
  - Slave response at N+k gives the master response at N+k+1.
- Back-to-back: after the response cycle the FSM is in IDLE, so the next s_*_request comes at the earliest 2 cycles after the previous one.
- Timeout response at cycle ISSUE+TIMEOUT_CYCLES+1.
- busy is high from ISSUE through the cycle before the master response.

## Test plan
- m0 read of 0x00000010 with the slave responding 1 cycle after s_read_request with data 0x12345678 → single s_read_request with s_address=0x10; m0_read_response pulse with m0_read_data=0x12345678 two cycles after the request; m1 outputs stay 0.
- m0 and m1 write simultaneously and continuously (addresses 0x100/0x200) → s_address alternates 0x100, 0x200, 0x100… starting with m0 after reset; each master gets one write_response per grant.
- m1 write with strobe 4'b0011 and data 0xAABBCCDD, slave delaying 7 cycles → s outputs stable for all 7 cycles; m1_write_response one cycle after s_write_response.
- TIMEOUT_CYCLES=4, m0 read and the slave never responds → m0_read_response and m0_error at ISSUE+5, data 0xDEADBEEF, timeout_flag=1; a late s_read_response produces no pulse.
- reset asserted during WAIT → no response pulses; all outputs 0 next cycle; the next contention grants m0 first.
- m1 raises both read and write → write issued first, read issued in the following transaction.

Source files
------------

// File: rtl/memory_bus_arbiter.sv
// rtl/memory_bus_arbiter.sv - two-master round-robin arbiter onto one synchronous memory port
// Serialises m0/m1 transactions, registers every output, forces an error response on slave timeout.
module memory_bus_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      m0_read_request,
   input  logic                      m0_write_request,
   input  logic [ADDR_WIDTH-1:0]     m0_address,
   input  logic [DATA_WIDTH-1:0]     m0_write_data,
   input  logic [DATA_WIDTH/8-1:0]   m0_write_strobe,
   output logic [DATA_WIDTH-1:0]     m0_read_data,
   output logic                      m0_read_response,
   output logic                      m0_write_response,
   output logic                      m0_error,
   input  logic                      m1_read_request,
   input  logic                      m1_write_request,
   input  logic [ADDR_WIDTH-1:0]     m1_address,
   input  logic [DATA_WIDTH-1:0]     m1_write_data,
   input  logic [DATA_WIDTH/8-1:0]   m1_write_strobe,
   output logic [DATA_WIDTH-1:0]     m1_read_data,
   output logic                      m1_read_response,
   output logic                      m1_write_response,
   output logic                      m1_error,
   output logic                      s_read_request,
   output logic                      s_write_request,
   output logic [ADDR_WIDTH-1:0]     s_address,
   output logic [DATA_WIDTH-1:0]     s_write_data,
   output logic [DATA_WIDTH/8-1:0]   s_write_strobe,
   input  logic [DATA_WIDTH-1:0]     s_read_data,
   input  logic                      s_read_response,
   input  logic                      s_write_response,
   output logic                      busy,
   output logic                      owner,
   output logic                      timeout_flag
);
   localparam int CW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int CW1 = CW + 1;
   localparam logic [CW:0] T_LAST = CW1'(TIMEOUT_CYCLES);
   localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hDEADBEEF);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t state, state_n;
   logic last_grant, is_write;
   logic [CW-1:0] wait_cnt;

   logic m0_pend, m1_pend, any_pend, grant, grant_sel, grant_wr;
   logic resp_match, timeout_hit, done, expired, finish;
   logic s_rd_n, s_wr_n, busy_n;
   logic [DATA_WIDTH-1:0] rdata_n;

   // Arbitration and completion decode shared by next-state and output logic
   always_comb begin
      m0_pend    = m0_read_request | m0_write_request;
      m1_pend    = m1_read_request | m1_write_request;
      any_pend   = m0_pend | m1_pend;
      grant_sel  = (m0_pend && m1_pend) ? ~last_grant : m1_pend;
      grant_wr   = grant_sel ? m1_write_request : m0_write_request;
      grant      = (state == S_IDLE) && any_pend;
      resp_match = is_write ? s_write_response : s_read_response;
      timeout_hit = (TIMEOUT_CYCLES != 0) && (state == S_WAIT) &&
                    (({1'b0, wait_cnt} + CW1'(1)) == T_LAST);
      done       = (state != S_IDLE) && resp_match;
      expired    = timeout_hit && !resp_match;
      finish     = done || expired;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  if (any_pend) state_n = S_ISSUE;
         S_ISSUE: state_n = resp_match ? S_IDLE : S_WAIT;
         S_WAIT:  if (finish) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      s_rd_n  = grant && !grant_wr;
      s_wr_n  = grant && grant_wr;
      busy_n  = (state_n != S_IDLE);
      rdata_n = '0;
      if (finish && !is_write) rdata_n = expired ? ERR_DATA : s_read_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= S_IDLE;
         last_grant        <= 1'b1;
         owner             <= 1'b0;
         is_write          <= 1'b0;
         wait_cnt          <= '0;
         timeout_flag      <= 1'b0;
         busy              <= 1'b0;
         s_read_request    <= 1'b0;
         s_write_request   <= 1'b0;
         s_address         <= '0;
         s_write_data      <= '0;
         s_write_strobe    <= '0;
         m0_read_data      <= '0;
         m0_read_response  <= 1'b0;
         m0_write_response <= 1'b0;
         m0_error          <= 1'b0;
         m1_read_data      <= '0;
         m1_read_response  <= 1'b0;
         m1_write_response <= 1'b0;
         m1_error          <= 1'b0;
      end else begin
         state           <= state_n;
         busy            <= busy_n;
         s_read_request  <= s_rd_n;
         s_write_request <= s_wr_n;
         if (grant) begin
            last_grant     <= grant_sel;
            owner          <= grant_sel;
            is_write       <= grant_wr;
            s_address      <= grant_sel ? m1_address : m0_address;
            s_write_data   <= grant_sel ? m1_write_data : m0_write_data;
            s_write_strobe <= grant_wr ? (grant_sel ? m1_write_strobe : m0_write_strobe) : '0;
         end
         if (state == S_ISSUE)     wait_cnt <= '0;
         else if (state == S_WAIT) wait_cnt <= wait_cnt + CW'(1);
         if (expired) timeout_flag <= 1'b1;
         // Completion is routed to the owner only; the other master's outputs stay low
         m0_read_response  <= finish && !is_write && !owner;
         m0_write_response <= finish && is_write && !owner;
         m0_error          <= expired && !owner;
         m0_read_data      <= owner ? '0 : rdata_n;
         m1_read_response  <= finish && !is_write && owner;
         m1_write_response <= finish && is_write && owner;
         m1_error          <= expired && owner;
         m1_read_data      <= owner ? rdata_n : '0;
      end
   end
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb/tb_memory_bus_arbiter.sv - scoreboard bench for memory_bus_arbiter
`timescale 1ns/1ps
module tb_memory_bus_arbiter;
   typedef struct packed {logic wr; logic [31:0] addr; logic [31:0] data; logic [3:0] strb;} iss_t;
   typedef struct packed {logic m; logic wr; logic [31:0] data; logic err;} rsp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic m0_read_request, m0_write_request, m1_read_request, m1_write_request;
   logic [31:0] m0_address, m0_write_data, m1_address, m1_write_data;
   logic [3:0] m0_write_strobe, m1_write_strobe;

   logic [31:0] m0_read_data, m1_read_data, s_address, s_write_data, s_read_data;
   logic m0_read_response, m0_write_response, m0_error;
   logic m1_read_response, m1_write_response, m1_error;
   logic s_read_request, s_write_request, s_read_response, s_write_response;
   logic [3:0] s_write_strobe;
   logic busy, owner, timeout_flag;

   logic [31:0] t_m0_read_data, t_m1_read_data, t_s_address, t_s_write_data, t_s_read_data;
   logic t_m0_read_response, t_m0_write_response, t_m0_error;
   logic t_m1_read_response, t_m1_write_response, t_m1_error;
   logic t_s_read_request, t_s_write_request, t_s_read_response, t_s_write_response;
   logic [3:0] t_s_write_strobe;
   logic t_busy, t_owner, t_timeout_flag;

   int n_cmp = 0;
   int n_bad = 0;
   logic mon_en;
   iss_t exp_iss[$];
   rsp_t exp_rsp[$];

   memory_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(255)) dut (
      .clk(clk), .reset(reset),
      .m0_read_request(m0_read_request), .m0_write_request(m0_write_request),
      .m0_address(m0_address), .m0_write_data(m0_write_data), .m0_write_strobe(m0_write_strobe),
      .m0_read_data(m0_read_data), .m0_read_response(m0_read_response),
      .m0_write_response(m0_write_response), .m0_error(m0_error),
      .m1_read_request(m1_read_request), .m1_write_request(m1_write_request),
      .m1_address(m1_address), .m1_write_data(m1_write_data), .m1_write_strobe(m1_write_strobe),
      .m1_read_data(m1_read_data), .m1_read_response(m1_read_response),
      .m1_write_response(m1_write_response), .m1_error(m1_error),
      .s_read_request(s_read_request), .s_write_request(s_write_request),
      .s_address(s_address), .s_write_data(s_write_data), .s_write_strobe(s_write_strobe),
      .s_read_data(s_read_data), .s_read_response(s_read_response),
      .s_write_response(s_write_response),
      .busy(busy), .owner(owner), .timeout_flag(timeout_flag)
   );

   memory_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut_to (
      .clk(clk), .reset(reset),
      .m0_read_request(m0_read_request), .m0_write_request(m0_write_request),
      .m0_address(m0_address), .m0_write_data(m0_write_data), .m0_write_strobe(m0_write_strobe),
      .m0_read_data(t_m0_read_data), .m0_read_response(t_m0_read_response),
      .m0_write_response(t_m0_write_response), .m0_error(t_m0_error),
      .m1_read_request(m1_read_request), .m1_write_request(m1_write_request),
      .m1_address(m1_address), .m1_write_data(m1_write_data), .m1_write_strobe(m1_write_strobe),
      .m1_read_data(t_m1_read_data), .m1_read_response(t_m1_read_response),
      .m1_write_response(t_m1_write_response), .m1_error(t_m1_error),
      .s_read_request(t_s_read_request), .s_write_request(t_s_write_request),
      .s_address(t_s_address), .s_write_data(t_s_write_data), .s_write_strobe(t_s_write_strobe),
      .s_read_data(t_s_read_data), .s_read_response(t_s_read_response),
      .s_write_response(t_s_write_response),
      .busy(t_busy), .owner(t_owner), .timeout_flag(t_timeout_flag)
   );

   // Behavioural slave: answers sl_delay cycles after the issue pulse (0 = same cycle)
   int sl_delay, sl_cnt;
   logic [31:0] sl_rdata;
   logic sl_pend, sl_wr;
   always @(posedge clk) begin
      if (reset) sl_pend <= 1'b0;
      else if ((s_read_request || s_write_request) && sl_delay > 0) begin
         sl_pend <= 1'b1;
         sl_wr   <= s_write_request;
         sl_cnt  <= sl_delay - 1;
      end else if (sl_pend) begin
         if (sl_cnt == 0) sl_pend <= 1'b0;
         else sl_cnt <= sl_cnt - 1;
      end
   end
   assign s_read_response  = (s_read_request && sl_delay == 0) || (sl_pend && !sl_wr && sl_cnt == 0);
   assign s_write_response = (s_write_request && sl_delay == 0) || (sl_pend && sl_wr && sl_cnt == 0);
   assign s_read_data      = s_read_response ? sl_rdata : 32'h0;
   assign t_s_read_data    = 32'h0;

   function automatic logic [142:0] main_outs();
      return {s_read_request, s_write_request, s_address, s_write_data, s_write_strobe, busy, owner,
              timeout_flag, m0_read_data, m0_read_response, m0_write_response, m0_error,
              m1_read_data, m1_read_response, m1_write_response, m1_error};
   endfunction

   function automatic logic [142:0] to_outs();
      return {t_s_read_request, t_s_write_request, t_s_address, t_s_write_data, t_s_write_strobe,
              t_busy, t_owner, t_timeout_flag, t_m0_read_data, t_m0_read_response,
              t_m0_write_response, t_m0_error, t_m1_read_data, t_m1_read_response,
              t_m1_write_response, t_m1_error};
   endfunction

   // Scoreboard consumer: every issue and every master response pops an expectation
   logic [1:0] mon_rr, mon_wr, mon_err;
   logic [31:0] mon_rd [2];
   assign mon_rr = {m1_read_response, m0_read_response};
   assign mon_wr = {m1_write_response, m0_write_response};
   assign mon_err = {m1_error, m0_error};
   assign mon_rd[0] = m0_read_data;
   assign mon_rd[1] = m1_read_data;
   iss_t got_iss, want_iss;
   rsp_t got_rsp, want_rsp;

   always @(negedge clk) begin
      if (mon_en && !reset) begin
         if (s_read_request || s_write_request) begin
            n_cmp++;
            got_iss = {s_write_request, s_address, (s_write_request ? s_write_data : 32'h0), s_write_strobe};
            if (exp_iss.size() == 0) begin
               n_bad++;
               $display("FAIL issue_unexpected: got %h, required no issue", got_iss);
            end else begin
               want_iss = exp_iss.pop_front();
               if (!want_iss.wr) want_iss.data = 32'h0;
               if (got_iss !== want_iss) begin
                  n_bad++;
                  $display("FAIL issue: got %h, required %h", got_iss, want_iss);
               end
            end
         end
         for (int m = 0; m < 2; m++) begin
            if (mon_rr[m] || mon_wr[m]) begin
               n_cmp++;
               got_rsp = {1'(m), mon_wr[m], (mon_rr[m] ? mon_rd[m] : 32'h0), mon_err[m]};
               if (exp_rsp.size() == 0) begin
                  n_bad++;
                  $display("FAIL response_unexpected: got %h, required no response", got_rsp);
               end else begin
                  want_rsp = exp_rsp.pop_front();
                  if (got_rsp !== want_rsp) begin
                     n_bad++;
                     $display("FAIL response: got %h, required %h", got_rsp, want_rsp);
                  end
               end
            end
         end
      end
   end

   task automatic push_iss(input logic wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      exp_iss.push_back({wr, addr, data, strb});
   endtask

   task automatic push_rsp(input logic m, input logic wr, input logic [31:0] data, input logic err);
      exp_rsp.push_back({m, wr, data, err});
   endtask

   task automatic drain_check(input string name);
      n_cmp++;
      if (exp_iss.size() != 0 || exp_rsp.size() != 0) begin
         n_bad++;
         $display("FAIL %s_drain: got %0d issues / %0d responses outstanding, required 0 / 0",
                  name, exp_iss.size(), exp_rsp.size());
      end
      exp_iss.delete();
      exp_rsp.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      {m0_read_request, m0_write_request, m1_read_request, m1_write_request} = 4'b0;
      {t_s_read_response, t_s_write_response} = 2'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++;
      if (main_outs() !== 143'h0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h, required 0", main_outs());
      end
      n_cmp++;
      if (to_outs() !== 143'h0) begin
         n_bad++;
         $display("FAIL reset_outputs_to: got %h, required 0", to_outs());
      end
      reset = 1'b0;
   endtask

   task automatic test_single_read();
      int sreq_at = -1, rsp_at = -1, nreq = 0;
      bit m1_noise = 0;
      sl_delay = 1;
      sl_rdata = 32'h12345678;
      push_iss(1'b0, 32'h10, 32'h0, 4'h0);
      push_rsp(1'b0, 1'b0, 32'h12345678, 1'b0);
      m0_address = 32'h10;
      m0_write_data = 32'h0;
      m0_read_request = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (s_read_request || s_write_request) begin
            nreq++;
            if (sreq_at < 0) sreq_at = i;
         end
         if (m1_read_response || m1_write_response || m1_error || m1_read_data != 32'h0) m1_noise = 1;
         if (m0_read_response && rsp_at < 0) begin
            rsp_at = i;
            m0_read_request = 1'b0;
         end
      end
      n_cmp++;
      if (sreq_at != 1 || rsp_at != 3) begin
         n_bad++;
         $display("FAIL read_latency: got issue@%0d response@%0d, required issue@1 response@3", sreq_at, rsp_at);
      end
      n_cmp++;
      if (nreq != 1) begin
         n_bad++;
         $display("FAIL read_issue_count: got %0d, required 1", nreq);
      end
      n_cmp++;
      if (m1_noise) begin
         n_bad++;
         $display("FAIL read_m1_quiet: got activity, required none");
      end
      drain_check("single_read");
   endtask

   task automatic test_round_robin();
      int c0 = 0, c1 = 0;
      do_reset();
      sl_delay = 1;
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) push_iss(1'b1, 32'h100, 32'hA0A00000, 4'hF);
         else push_iss(1'b1, 32'h200, 32'hB1B10000, 4'hF);
         push_rsp(1'(k % 2), 1'b1, 32'h0, 1'b0);
      end
      m0_address = 32'h100; m0_write_data = 32'hA0A00000; m0_write_strobe = 4'hF;
      m1_address = 32'h200; m1_write_data = 32'hB1B10000; m1_write_strobe = 4'hF;
      m0_write_request = 1'b1;
      m1_write_request = 1'b1;
      for (int i = 0; i < 60 && (c0 + c1) < 6; i++) begin
         @(negedge clk);
         if (m0_write_response) c0++;
         if (m1_write_response) c1++;
         if (c0 + c1 >= 6) {m0_write_request, m1_write_request} = 2'b0;
      end
      {m0_write_request, m1_write_request} = 2'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (c0 != 3) begin
         n_bad++;
         $display("FAIL rr_m0_count: got %0d, required 3", c0);
      end
      n_cmp++;
      if (c1 != 3) begin
         n_bad++;
         $display("FAIL rr_m1_count: got %0d, required 3", c1);
      end
      drain_check("round_robin");
   endtask

   task automatic test_stable_write();
      int sreq_at = -1, sresp_at = -1, mresp_at = -1;
      sl_delay = 7;
      push_iss(1'b1, 32'h300, 32'hAABBCCDD, 4'b0011);
      push_rsp(1'b1, 1'b1, 32'h0, 1'b0);
      m1_address = 32'h300; m1_write_data = 32'hAABBCCDD; m1_write_strobe = 4'b0011;
      m1_write_request = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (s_write_request && sreq_at < 0) sreq_at = i;
         if (s_write_response && sresp_at < 0) sresp_at = i;
         if (sreq_at > 0 && busy) begin
            n_cmp++;
            if ({s_address, s_write_data, s_write_strobe} !== {32'h300, 32'hAABBCCDD, 4'b0011}) begin
               n_bad++;
               $display("FAIL write_stable@%0d: got %h %h %b, required 300 aabbccdd 0011",
                        i, s_address, s_write_data, s_write_strobe);
            end
         end
         if (m1_write_response && mresp_at < 0) begin
            mresp_at = i;
            m1_write_request = 1'b0;
         end
      end
      n_cmp++;
      if (sreq_at < 0 || sresp_at - sreq_at != 7 || mresp_at - sresp_at != 1) begin
         n_bad++;
         $display("FAIL write_delay_timing: got issue@%0d slave@%0d master@%0d, required slave=issue+7 master=slave+1",
                  sreq_at, sresp_at, mresp_at);
      end
      drain_check("stable_write");
   endtask

   task automatic test_timeout();
      int iss_at = -1, rsp_at = -1, late = 0;
      logic [33:0] got = '0;
      mon_en = 1'b0;
      do_reset();
      sl_delay = 1000;
      m0_address = 32'h40;
      m0_read_request = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (t_s_read_request && iss_at < 0) iss_at = i;
         if (t_m0_read_response && rsp_at < 0) begin
            rsp_at = i;
            got = {t_m0_read_response, t_m0_error, t_m0_read_data};
            m0_read_request = 1'b0;
         end
      end
      n_cmp++;
      if (iss_at < 0 || rsp_at - iss_at != 5) begin
         n_bad++;
         $display("FAIL timeout_latency: got issue@%0d response@%0d, required response=issue+5", iss_at, rsp_at);
      end
      n_cmp++;
      if (got !== {1'b1, 1'b1, 32'hDEADBEEF}) begin
         n_bad++;
         $display("FAIL timeout_response: got %h, required 3deadbeef", got);
      end
      t_s_read_response = 1'b1;
      @(negedge clk);
      t_s_read_response = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (t_m0_read_response || t_m0_write_response || t_m0_error ||
             t_m1_read_response || t_m1_write_response || t_m1_error) late++;
      end
      n_cmp++;
      if (late != 0) begin
         n_bad++;
         $display("FAIL timeout_late_response: got %0d pulses, required 0", late);
      end
      n_cmp++;
      if ({t_timeout_flag, timeout_flag} !== 2'b10) begin
         n_bad++;
         $display("FAIL timeout_flag: got %b, required 10", {t_timeout_flag, timeout_flag});
      end
      do_reset();
      exp_iss.delete();
      exp_rsp.delete();
      mon_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      int first_addr = -1, pulses = 0;
      sl_delay = 1000;
      push_iss(1'b1, 32'h600, 32'h66666666, 4'hF);
      m0_address = 32'h600; m0_write_data = 32'h66666666; m0_write_strobe = 4'hF;
      m0_write_request = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL midreset_busy: got %b, required 1", busy);
      end
      reset = 1'b1;
      m0_write_request = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (main_outs() !== 143'h0) begin
         n_bad++;
         $display("FAIL midreset_outputs: got %h, required 0", main_outs());
      end
      reset = 1'b0;
      sl_delay = 0;
      sl_rdata = 32'h0BADF00D;
      push_iss(1'b0, 32'h700, 32'h0, 4'h0);
      push_iss(1'b0, 32'h800, 32'h0, 4'h0);
      push_rsp(1'b0, 1'b0, 32'h0BADF00D, 1'b0);
      push_rsp(1'b1, 1'b0, 32'h0BADF00D, 1'b0);
      m0_address = 32'h700;
      m1_address = 32'h800;
      m0_read_request = 1'b1;
      m1_read_request = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (s_read_request && first_addr < 0) first_addr = int'(s_address);
         if (m0_read_response) begin m0_read_request = 1'b0; pulses++; end
         if (m1_read_response) begin m1_read_request = 1'b0; pulses++; end
      end
      n_cmp++;
      if (first_addr != 32'h700 || pulses != 2) begin
         n_bad++;
         $display("FAIL midreset_first_grant: got addr %h / %0d responses, required 700 / 2", first_addr, pulses);
      end
      drain_check("reset_mid");
   endtask

   task automatic test_both_rw();
      int first_wr = -1;
      sl_delay = 2;
      sl_rdata = 32'h87654321;
      push_iss(1'b1, 32'h500, 32'h55, 4'hF);
      push_iss(1'b0, 32'h500, 32'h0, 4'h0);
      push_rsp(1'b1, 1'b1, 32'h0, 1'b0);
      push_rsp(1'b1, 1'b0, 32'h87654321, 1'b0);
      m1_address = 32'h500; m1_write_data = 32'h55; m1_write_strobe = 4'hF;
      m1_write_request = 1'b1;
      m1_read_request = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if ((s_read_request || s_write_request) && first_wr < 0) first_wr = int'(s_write_request);
         if (m1_write_response) m1_write_request = 1'b0;
         if (m1_read_response) m1_read_request = 1'b0;
      end
      n_cmp++;
      if (first_wr != 1) begin
         n_bad++;
         $display("FAIL rw_write_first: got first issue write=%0d, required 1", first_wr);
      end
      drain_check("both_rw");
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      mon_en = 1'b0;
      sl_delay = 0;
      sl_rdata = 32'h0;
      {m0_read_request, m0_write_request, m1_read_request, m1_write_request} = 4'b0;
      {m0_address, m0_write_data, m1_address, m1_write_data} = '0;
      {m0_write_strobe, m1_write_strobe} = '0;
      {t_s_read_response, t_s_write_response} = 2'b0;
      test_reset();
      mon_en = 1'b1;
      test_single_read();
      test_round_robin();
      test_stable_write();
      test_timeout();
      test_round_robin();
      test_reset_mid();
      test_both_rw();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
